// File: rtl/axis_uart_pkg.sv
// ----------------------------------------------------------------------------
// axis_uart_pkg
// Shared definitions for the AxisUart byte framing layer (TX framer today,
// RX deframer later).
//   - DEF_START_BYTE / DEF_STOP_BYTE / DEF_ESCAPE_BYTE : default delimiters
//   - framer_state_e : TX framer FSM states
//   - is_special()   : true for bytes that must be escaped inside a frame
// ----------------------------------------------------------------------------
package axis_uart_pkg;

    localparam logic [7:0] DEF_START_BYTE  = 8'h7D;
    localparam logic [7:0] DEF_STOP_BYTE   = 8'h7E;
    localparam logic [7:0] DEF_ESCAPE_BYTE = 8'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a packet, nothing in flight
        ST_DATA = 2'd1,   // passing payload bytes through
        ST_ESC  = 2'd2,   // escape prefix loaded, held byte still to send
        ST_STOP = 2'd3    // last beat consumed, STOP still to send
    } framer_state_e;

    function automatic logic is_special(
        input logic [7:0] b,
        input logic [7:0] start_b,
        input logic [7:0] stop_b,
        input logic [7:0] esc_b
    );
        return (b == start_b) || (b == stop_b) || (b == esc_b);
    endfunction

endpackage

// File: rtl/axis_uart_tx_framer_if.sv
// ----------------------------------------------------------------------------
// axis_uart_tx_framer_if
// Byte-wide AXI-Stream bundle used on both sides of the TX framer.
//   tvalid/tready : handshake
//   tdata[7:0]    : byte
//   tkeep         : 1 = byte present, 0 = null beat
//   tlast         : last beat of a packet
// master drives tvalid/tdata/tkeep/tlast, slave drives tready.
// ----------------------------------------------------------------------------
interface axis_uart_tx_framer_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tkeep;
    logic       tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast,
                    input  tready);
    modport slave  (input  tvalid, input  tdata, input  tkeep, input  tlast,
                    output tready);
endinterface

// File: rtl/axis_uart_tx_framer.sv
// ----------------------------------------------------------------------------
// axis_uart_tx_framer
// Turns AXI-Stream packets into framed byte streams for the UART transmitter:
//   START, payload (special bytes prefixed with ESCAPE), STOP.
// Ports:
//   aclk    : clock
//   aresetn : asynchronous, active-low reset
//   target  : payload input (slave); tkeep=0 beats carry no byte
//   txbyte  : framed byte output (master); tkeep constant 1, tlast unused (0)
// The output is a single register slot: a byte loads only when the slot is
// free (empty or being accepted this cycle), so backpressure stalls every
// state without losing or duplicating bytes.
// ----------------------------------------------------------------------------
module axis_uart_tx_framer
    import axis_uart_pkg::*;
#(
    parameter logic [7:0] START_BYTE  = DEF_START_BYTE,
    parameter logic [7:0] STOP_BYTE   = DEF_STOP_BYTE,
    parameter logic [7:0] ESCAPE_BYTE = DEF_ESCAPE_BYTE
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    axis_uart_tx_framer_if.slave          target,
    axis_uart_tx_framer_if.master         txbyte
);

    framer_state_e state_q, state_d;
    logic          tvalid_q, tvalid_d;
    logic [7:0]    tdata_q,  tdata_d;
    logic [7:0]    hold_q,   hold_d;
    logic          last_q,   last_d;

    logic out_free;
    logic in_hs;

    assign out_free = !tvalid_q || txbyte.tready;

    // Input is only taken in DATA and only when the output slot can accept
    // whatever that beat produces; independent of target.tvalid.
    assign target.tready = (state_q == ST_DATA) && out_free;
    assign in_hs         = target.tvalid && target.tready;

    assign txbyte.tvalid = tvalid_q;
    assign txbyte.tdata  = tdata_q;
    assign txbyte.tkeep  = 1'b1;
    assign txbyte.tlast  = 1'b0;

    always_comb begin
        state_d = state_q;
        // Without a new load, an accepted byte empties the slot.
        tvalid_d = tvalid_q && !txbyte.tready;
        tdata_d  = tdata_q;
        hold_d   = hold_q;
        last_d   = last_q;

        unique case (state_q)
            ST_IDLE: begin
                if (target.tvalid && out_free) begin
                    tvalid_d = 1'b1;
                    tdata_d  = START_BYTE;
                    state_d  = ST_DATA;
                end
            end

            ST_DATA: begin
                if (in_hs) begin
                    if (target.tkeep) begin
                        if (is_special(target.tdata, START_BYTE, STOP_BYTE, ESCAPE_BYTE)) begin
                            tvalid_d = 1'b1;
                            tdata_d  = ESCAPE_BYTE;
                            hold_d   = target.tdata;
                            last_d   = target.tlast;
                            state_d  = ST_ESC;
                        end else begin
                            tvalid_d = 1'b1;
                            tdata_d  = target.tdata;
                            state_d  = target.tlast ? ST_STOP : ST_DATA;
                        end
                    end else begin
                        // Null beat: nothing to emit, but tlast still ends the frame.
                        state_d = target.tlast ? ST_STOP : ST_DATA;
                    end
                end
            end

            ST_ESC: begin
                if (out_free) begin
                    tvalid_d = 1'b1;
                    tdata_d  = hold_q;
                    state_d  = last_q ? ST_STOP : ST_DATA;
                end
            end

            ST_STOP: begin
                if (out_free) begin
                    tvalid_d = 1'b1;
                    tdata_d  = STOP_BYTE;
                    state_d  = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            tvalid_q <= 1'b0;
            tdata_q  <= 8'h00;
            hold_q   <= 8'h00;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_axis_uart_tx_framer.sv
// ----------------------------------------------------------------------------
// tb_axis_uart_tx_framer
// Randomised bench with a packet-level framing model and a deframing
// scoreboard. Inputs change 1 time unit after the rising edge; outputs are
// observed on the falling edge.
// ----------------------------------------------------------------------------
module tb_axis_uart_tx_framer;

    localparam logic [7:0] K_START = 8'h7D;
    localparam logic [7:0] K_STOP  = 8'h7E;
    localparam logic [7:0] K_ESC   = 8'h7F;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axis_uart_tx_framer_if tgt_if ();
    axis_uart_tx_framer_if tx_if ();

    axis_uart_tx_framer dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .target  (tgt_if),
        .txbyte  (tx_if)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge aclk) cyc++;

    // Sink readiness, redrawn every cycle.
    int ready_pct = 100;
    always begin
        tx_if.tready = ($urandom_range(0, 99) < ready_pct);
        @(posedge aclk);
        #1;
    end

    // Output monitor: records each byte whose handshake completes on the
    // coming rising edge, and checks that a stalled byte is held.
    logic [7:0] out_q[$];
    int         out_cyc[$];
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev  = 8'h00;

    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", tx_if.tvalid, 1'b1);
                chk("stall_data", tx_if.tdata, data_prev);
            end
            if (tgt_if.tready)
                chk("in_ready_needs_out_free", (!tx_if.tvalid || tx_if.tready), 1'b1);
            if (tx_if.tvalid && tx_if.tready) begin
                out_q.push_back(tx_if.tdata);
                out_cyc.push_back(cyc);
            end
            stall_prev = tx_if.tvalid && !tx_if.tready;
            data_prev  = tx_if.tdata;
        end
    end

    // Reference model: a packet becomes START, each present byte (escaped
    // when it collides with a delimiter), STOP.
    logic [7:0] pkt_d[$];
    logic       pkt_k[$];
    logic [7:0] exp_q[$];
    logic [7:0] payload_q[$];

    task automatic add_beat(input logic [7:0] d, input logic k);
        pkt_d.push_back(d);
        pkt_k.push_back(k);
    endtask

    task automatic model_pkt();
        exp_q.push_back(K_START);
        foreach (pkt_d[i]) begin
            if (pkt_k[i]) begin
                payload_q.push_back(pkt_d[i]);
                if (pkt_d[i] == K_START || pkt_d[i] == K_STOP || pkt_d[i] == K_ESC)
                    exp_q.push_back(K_ESC);
                exp_q.push_back(pkt_d[i]);
            end
        end
        exp_q.push_back(K_STOP);
    endtask

    // Drive the staged packet beat by beat; optional random idle gaps.
    task automatic send_pkt(input bit gaps);
        int n;
        model_pkt();
        foreach (pkt_d[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                tgt_if.tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge aclk);
                #1;
            end
            tgt_if.tvalid = 1'b1;
            tgt_if.tdata  = pkt_d[i];
            tgt_if.tkeep  = pkt_k[i];
            tgt_if.tlast  = (i == pkt_d.size() - 1);
            n = 0;
            do begin
                @(negedge aclk);
                n++;
            end while (!tgt_if.tready && n < 500);
            if (!tgt_if.tready) chk("in_handshake_timeout", 32'd0, 32'd1);
            @(posedge aclk);
            #1;
        end
        tgt_if.tvalid = 1'b0;
        tgt_if.tlast  = 1'b0;
        pkt_d.delete();
        pkt_k.delete();
    endtask

    task automatic check_out(input string name);
        int n = 0;
        while (out_q.size() < exp_q.size() && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        repeat (4) @(negedge aclk);
        chk($sformatf("%s_len", name), out_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < out_q.size())
                chk($sformatf("%s_b%0d", name, i), out_q[i], exp_q[i]);
        chk($sformatf("%s_idle_in_ready", name), tgt_if.tready, 1'b0);
        chk($sformatf("%s_idle_out_valid", name), tx_if.tvalid, 1'b0);
        chk($sformatf("%s_tkeep", name), tx_if.tkeep, 1'b1);
    endtask

    // Undo the framing of everything observed and compare with the payload sent.
    task automatic deframe_check(input string name, input int nframes);
        logic [7:0] got[$];
        int frames = 0;
        bit in_frame = 0;
        bit esc = 0;
        foreach (out_q[i]) begin
            if (esc) begin
                got.push_back(out_q[i]);
                esc = 0;
            end else if (out_q[i] == K_START && !in_frame) begin
                in_frame = 1;
            end else if (out_q[i] == K_STOP && in_frame) begin
                in_frame = 0;
                frames++;
            end else if (out_q[i] == K_ESC) begin
                esc = 1;
            end else begin
                got.push_back(out_q[i]);
            end
        end
        chk($sformatf("%s_frames", name), frames, nframes);
        chk($sformatf("%s_payload_len", name), got.size(), payload_q.size());
        foreach (payload_q[i])
            if (i < got.size())
                chk($sformatf("%s_payload%0d", name, i), got[i], payload_q[i]);
    endtask

    task automatic clear_all();
        out_q.delete();
        out_cyc.delete();
        exp_q.delete();
        payload_q.delete();
    endtask

    initial begin
        int n;
        tgt_if.tvalid = 1'b0;
        tgt_if.tdata  = 8'h00;
        tgt_if.tkeep  = 1'b1;
        tgt_if.tlast  = 1'b0;

        // Reset state
        repeat (3) @(negedge aclk);
        chk("rst_out_valid", tx_if.tvalid, 1'b0);
        chk("rst_in_ready", tgt_if.tready, 1'b0);
        chk("rst_out_data", tx_if.tdata, 8'h00);
        chk("rst_tkeep", tx_if.tkeep, 1'b1);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        // 1: plain packet, sink always ready, back-to-back output cycles
        ready_pct = 100;
        add_beat(8'h01, 1); add_beat(8'h02, 1); add_beat(8'h03, 1);
        send_pkt(0);
        check_out("t1");
        if (out_cyc.size() == 5)
            chk("t1_consecutive", out_cyc[4] - out_cyc[0], 4);
        else
            chk("t1_out_count", out_cyc.size(), 5);
        clear_all();

        // 2: every delimiter value in the payload
        add_beat(8'h7D, 1); add_beat(8'h41, 1); add_beat(8'h7F, 1); add_beat(8'h7E, 1);
        send_pkt(0);
        check_out("t2");
        clear_all();

        // 3: null beat inside a packet, then an empty packet
        add_beat(8'hAA, 1); add_beat(8'h99, 0); add_beat(8'hBB, 1);
        send_pkt(0);
        add_beat(8'h00, 0);
        send_pkt(0);
        check_out("t3");
        clear_all();

        // 4: sparse sink readiness
        ready_pct = 30;
        add_beat(8'h10, 1); add_beat(8'h20, 1); add_beat(8'h30, 1);
        send_pkt(0);
        check_out("t4");
        clear_all();

        // 5: asynchronous reset mid-frame
        ready_pct = 100;
        @(posedge aclk);
        #1;
        tgt_if.tvalid = 1'b1;
        tgt_if.tdata  = 8'h10;
        tgt_if.tkeep  = 1'b1;
        tgt_if.tlast  = 1'b0;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!tgt_if.tready && n < 100);
        if (!tgt_if.tready) chk("t5_first_beat_timeout", 32'd0, 32'd1);
        @(posedge aclk);
        #1 tgt_if.tdata = 8'h20;
        n = 0;
        while (out_q.size() < 2 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        @(posedge aclk);
        #1;
        chk("t5_pre_out_valid", tx_if.tvalid, 1'b1);
        chk("t5_pre_in_ready", tgt_if.tready, 1'b1);
        if (out_q.size() >= 2) begin
            chk("t5_start", out_q[0], K_START);
            chk("t5_first", out_q[1], 8'h10);
        end else begin
            chk("t5_pre_count", out_q.size(), 2);
        end
        aresetn = 1'b0;
        tgt_if.tvalid = 1'b0;
        #1;
        chk("t5_rst_out_valid", tx_if.tvalid, 1'b0);
        chk("t5_rst_in_ready", tgt_if.tready, 1'b0);
        chk("t5_rst_out_data", tx_if.tdata, 8'h00);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        clear_all();
        @(posedge aclk);
        #1;
        add_beat(8'h55, 1);
        send_pkt(0);
        check_out("t5");
        clear_all();

        // 6: back-to-back packets with tvalid held high throughout
        add_beat(8'h01, 1); add_beat(8'h02, 1);
        send_pkt(0);
        add_beat(8'h03, 1); add_beat(8'h04, 1);
        send_pkt(0);
        check_out("t6");
        deframe_check("t6", 2);
        clear_all();

        // Random packets: special-heavy data, null beats, gaps, random sink
        ready_pct = 50;
        for (int p = 0; p < 25; p++) begin
            int len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                logic [7:0] d;
                d = ($urandom_range(0, 2) == 0) ? 8'(8'h7D + $urandom_range(0, 2))
                                                 : 8'($urandom_range(0, 255));
                add_beat(d, ($urandom_range(0, 4) != 0));
            end
            send_pkt(1);
        end
        check_out("rnd");
        deframe_check("rnd", 25);
        clear_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_uart_tx_framer.md
Name: axis_uart_tx_framer

Overview:
Upstream neighbour of the UART transmitter in the AxisUart interface. It takes AXI-Stream packets (bytes with tlast) and serialises each packet into a framed byte stream: START byte, escaped payload, STOP byte. Its output drives the transmitter's txbyte_* AXI-Stream byte input directly.

Parameters:
START_BYTE, 8'h7D, frame delimiter emitted before the first payload byte
STOP_BYTE, 8'h7E, frame delimiter emitted after the last payload byte
ESCAPE_BYTE, 8'h7F, prefix emitted before any payload byte equal to START/STOP/ESCAPE

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous assert, active-low
target_tvalid  in  1  payload beat valid
target_tready  out  1  payload beat accepted when tvalid && tready
target_tdata  in  8  payload byte
target_tkeep  in  1  1 = byte present; 0 = null beat (no byte)
target_tlast  in  1  last beat of packet
txbyte_tvalid  out  1  framed byte valid
txbyte_tready  in  1  transmitter ready
txbyte_tdata  out  8  framed byte
txbyte_tkeep  out  1  constant 1

Behaviour:
- Reset is asynchronous and active-low on aresetn; clock is aclk. Reset values: target_tready=0, txbyte_tvalid=0, txbyte_tdata=8'h00, state=IDLE, hold byte=0, last flag=0. txbyte_tkeep is constantly 1.
- Reset mid-frame discards the partial frame, with no STOP emitted. First activity after release is a new START.
- Output register: define out_free = !txbyte_tvalid || txbyte_tready. A new byte loads only when out_free. txbyte_tvalid stays high and txbyte_tdata stays stable until accepted. When no load occurs and txbyte_tready=1, txbyte_tvalid clears.
- target_tready = (state==DATA) && out_free. It is combinational from registered state and txbyte_tready, with no dependence on target_tvalid.
- special(b) = (b==START_BYTE)||(b==STOP_BYTE)||(b==ESCAPE_BYTE).
- FSM states: IDLE, DATA, ESC, STOP.
  - IDLE: target_tvalid && out_free -> load START_BYTE, go DATA. No input is consumed.
  - DATA, on input handshake:
    - tkeep=1, !special -> load tdata. Go STOP if tlast, else stay.
    - tkeep=1, special -> load ESCAPE_BYTE, hold<=tdata, last<=tlast, go ESC.
    - tkeep=0 -> load nothing. Go STOP if tlast, else stay.
  - ESC: out_free -> load hold. Go STOP if last, else DATA. target_tready=0 in this state.
  - STOP: out_free -> load STOP_BYTE, go IDLE.
- Throughput: one output byte per cycle with txbyte_tready held high. Escaped bytes cost one extra cycle.
- Latency: START is visible on txbyte the cycle after target_tvalid rises in IDLE. The first payload byte is accepted no earlier than that cycle.
- Back-to-back packets: after STOP loads, IDLE needs at least one cycle before the next START. There is no merging of frames.
- Empty packet (single beat, tkeep=0, tlast=1) emits START, STOP.
- Backpressure (txbyte_tready low) stalls all states; no byte is lost or duplicated.

Decomposition:
- Package axis_uart_pkg holds:
  - default START/STOP/ESCAPE constants, shared with the future RX deframer;
  - the framer state enum;
  - function is_special(byte, start, stop, esc).
- No sub-module. The output register and FSM are a single always_ff plus the combinational target_tready.

Test Plan:
1. Packet {8'h01,8'h02,8'h03}, last on 03, sink always ready -> txbyte sequence 7D,01,02,03,7E. Five consecutive valid cycles after START.
2. Packet {8'h7D,8'h41,8'h7F,8'h7E}, last on 7E -> 7D,7F,7D,41,7F,7F,7F,7E,7E.
3. Packet {8'hAA, null beat tkeep=0, 8'hBB last}, then single null beat with tlast -> 7D,AA,BB,7E,7D,7E.
4. Packet {10,20,30} with txbyte_tready random 30% high:
   - output sequence 7D,10,20,30,7E;
   - tdata stable whenever valid && !ready;
   - target_tready never high in IDLE/ESC/STOP.
5. Assert aresetn low for 2 cycles after START+10 have been emitted of packet {10,20,30}:
   - txbyte_tvalid=0 and target_tready=0 immediately (async);
   - next packet {55} emits 7D,55,7E.
6. Back-to-back two-byte packets {01,02},{03,04} streamed continuously -> 7D,01,02,7E,7D,03,04,7E, no byte loss. Scoreboard checks the deframed output equals the input.
